// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - datapath fetch port and pmem line-fill port of icache_dm
//
// Purpose: bundles the fetch request/response and line-fill signals of the
//          direct-mapped instruction cache.
// Ports (members):
//   icache_read/icache_addr   fetch request, held until icache_resp
//   icache_rdata/icache_resp  fetched word and served strobe
//   pmem_read/pmem_address    line-fill request and line-aligned address
//   pmem_rdata/pmem_resp      fill line and single-cycle completion pulse
// Modports: master = datapath + memory side, slave = cache.

interface icache_dm_if #(
   parameter int S_LINE = 256
);
   logic              icache_read;
   logic [31:0]       icache_addr;
   logic [31:0]       icache_rdata;
   logic              icache_resp;
   logic              pmem_read;
   logic [31:0]       pmem_address;
   logic [S_LINE-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      output icache_read, icache_addr, pmem_rdata, pmem_resp,
      input  icache_rdata, icache_resp, pmem_read, pmem_address
   );

   modport slave (
      input  icache_read, icache_addr, pmem_rdata, pmem_resp,
      output icache_rdata, icache_resp, pmem_read, pmem_address
   );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with hit/miss counters
//
// Purpose: same-cycle hits; on a miss fetch one full line from pmem, install it,
//          then serve the request from the cache on the following cycle.
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   bus           icache_dm_if.slave (fetch port + pmem fill port)
//   hit_count_o   cycles with icache_resp=1 (wraps)
//   miss_count_o  number of misses (IDLE->FETCH transitions, wraps)

module icache_dm #(
   parameter int S_INDEX  = 3,
   parameter int S_OFFSET = 5
) (
   input  logic        clk,
   input  logic        rst,
   icache_dm_if.slave  bus,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
);
   localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
   localparam int S_LINE = 8 * (2 ** S_OFFSET);
   localparam int S_WSEL = S_OFFSET - 2;
   localparam int N_SETS = 2 ** S_INDEX;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FETCH = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [N_SETS-1:0]       valid_q;
   logic [S_TAG-1:0]        tag_q  [N_SETS];
   logic [S_LINE-1:0]       data_q [N_SETS];
   // Latched {tag,index} of the line being filled.
   logic [31-S_OFFSET:0]    fill_q, fill_d;
   logic [31:0]             hit_q, hit_d;
   logic [31:0]             miss_q, miss_d;

   logic [S_TAG-1:0]        req_tag;
   logic [S_INDEX-1:0]      req_idx;
   logic [S_WSEL-1:0]       req_wsel;
   logic                    hit;
   logic                    fill_we;
   logic [S_INDEX-1:0]      fill_idx;
   logic [S_TAG-1:0]        fill_tag;
   logic                    unused_addr_bits;

   assign req_tag  = bus.icache_addr[31 -: S_TAG];
   assign req_idx  = bus.icache_addr[S_OFFSET +: S_INDEX];
   assign req_wsel = bus.icache_addr[2 +: S_WSEL];
   // Fetches are word aligned; the byte offset within the word carries no information.
   assign unused_addr_bits = ^bus.icache_addr[1:0];

   assign hit = bus.icache_read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

   assign fill_idx = fill_q[S_INDEX-1:0];
   assign fill_tag = fill_q[S_INDEX +: S_TAG];
   assign fill_we  = (state_q == FETCH) & bus.pmem_resp;

   assign bus.pmem_address = {fill_q, {S_OFFSET{1'b0}}};
   assign hit_count_o      = hit_q;
   assign miss_count_o     = miss_q;

   always_comb begin
      state_d          = state_q;
      fill_d           = fill_q;
      hit_d            = hit_q;
      miss_d           = miss_q;
      bus.icache_resp  = 1'b0;
      bus.icache_rdata = '0;
      bus.pmem_read    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.icache_read) begin
               if (hit) begin
                  bus.icache_resp  = 1'b1;
                  bus.icache_rdata = data_q[req_idx][{req_wsel, 5'b00000} +: 32];
                  hit_d            = hit_q + 32'd1;
               end else begin
                  state_d = FETCH;
                  fill_d  = bus.icache_addr[31:S_OFFSET];
                  miss_d  = miss_q + 32'd1;
               end
            end
         end
         default: begin
            // Fill goes to the latched set even if icache_addr moved meanwhile;
            // IDLE then re-evaluates whatever address is presented.
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         fill_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data contents are qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.pmem_rdata;
      end
   end
endmodule
